// File: rtl/az_to_lsp_f_poly.sv
// Az-to-LSP front end: reads LPC a[1..10] from scratch memory and writes the
// sum/difference polynomials f1[0..5] and f2[0..5] into the LSP_F region.
module az_to_lsp_f_poly #(
    parameter logic [2:0]  LSP_A  = 3'd4,
    parameter logic [1:0]  LSP_F  = 2'd1,
    parameter logic [15:0] F_INIT = 16'd2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic        busy,
    output logic        overflow,
    output logic [6:0]  scratch_mem_read_addr,
    input  logic [31:0] scratch_mem_in,
    output logic [6:0]  scratch_mem_write_addr,
    output logic [31:0] scratch_mem_out,
    output logic        scratch_mem_write_en
);

    // state  | meaning
    // IDLE   | waiting for start
    // INIT0  | write F_INIT to f1[0]
    // INIT1  | write F_INIT to f2[0]
    // RDA    | address a[i+1]
    // RDB    | address a[10-i], capture a[i+1]
    // CALC   | a[10-i] on read bus; write f1[i+1], register f2[i+1]
    // WRF2   | write f2[i+1], advance or finish
    // DONE   | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_INIT0, S_INIT1, S_RDA, S_RDB, S_CALC, S_WRF2, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  i_q, i_d;
    logic [15:0] a_lo_q, a_lo_d;
    logic [15:0] f1prev_q, f1prev_d;
    logic [15:0] f2prev_q, f2prev_d;
    logic [15:0] f2_q, f2_d;
    logic        overflow_q, overflow_d;
    logic [6:0]  read_addr_q, read_addr_d;

    logic [3:0]         idx_next;
    logic signed [16:0] s_sum, s_diff;
    logic signed [17:0] f1_wide, f2_wide;
    logic [15:0]        f1_sat, f2_sat;
    logic               f1_clamp, f2_clamp;

    assign idx_next = {1'b0, i_q} + 4'd1;

    // The halved sum/difference always fits 16 bits; only the accumulation
    // against the previous term can leave the Q12 range.
    always_comb begin
        s_sum   = $signed({a_lo_q[15], a_lo_q}) + $signed({scratch_mem_in[15], scratch_mem_in[15:0]});
        s_diff  = $signed({a_lo_q[15], a_lo_q}) - $signed({scratch_mem_in[15], scratch_mem_in[15:0]});
        f1_wide = $signed({{2{s_sum[16]}}, s_sum[16:1]}) - $signed({{2{f1prev_q[15]}}, f1prev_q});
        f2_wide = $signed({{2{s_diff[16]}}, s_diff[16:1]}) + $signed({{2{f2prev_q[15]}}, f2prev_q});
        f1_clamp = 1'b0;
        f2_clamp = 1'b0;
        f1_sat   = f1_wide[15:0];
        f2_sat   = f2_wide[15:0];
        if (f1_wide > 18'sd32767) begin
            f1_sat   = 16'h7fff;
            f1_clamp = 1'b1;
        end else if (f1_wide < -18'sd32768) begin
            f1_sat   = 16'h8000;
            f1_clamp = 1'b1;
        end
        if (f2_wide > 18'sd32767) begin
            f2_sat   = 16'h7fff;
            f2_clamp = 1'b1;
        end else if (f2_wide < -18'sd32768) begin
            f2_sat   = 16'h8000;
            f2_clamp = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        a_lo_d       = a_lo_q;
        f1prev_d     = f1prev_q;
        f2prev_d     = f2prev_q;
        f2_d         = f2_q;
        overflow_d   = overflow_q;
        read_addr_d  = read_addr_q;
        done         = 1'b0;
        scratch_mem_write_en   = 1'b0;
        scratch_mem_write_addr = 7'd0;
        scratch_mem_out        = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_INIT0;
                    overflow_d = 1'b0;
                end
            end
            S_INIT0: begin
                scratch_mem_write_en   = 1'b1;
                scratch_mem_write_addr = {LSP_F, 1'b0, 4'd0};
                scratch_mem_out        = {{16{F_INIT[15]}}, F_INIT};
                f1prev_d = F_INIT;
                i_d      = 3'd0;
                state_d  = S_INIT1;
            end
            S_INIT1: begin
                scratch_mem_write_en   = 1'b1;
                scratch_mem_write_addr = {LSP_F, 1'b1, 4'd0};
                scratch_mem_out        = {{16{F_INIT[15]}}, F_INIT};
                f2prev_d = F_INIT;
                state_d  = S_RDA;
            end
            S_RDA: begin
                read_addr_d = {LSP_A, idx_next};
                state_d     = S_RDB;
            end
            S_RDB: begin
                read_addr_d = {LSP_A, 4'd10 - {1'b0, i_q}};
                a_lo_d      = scratch_mem_in[15:0];
                state_d     = S_CALC;
            end
            S_CALC: begin
                scratch_mem_write_en   = 1'b1;
                scratch_mem_write_addr = {LSP_F, 1'b0, idx_next};
                scratch_mem_out        = {{16{f1_sat[15]}}, f1_sat};
                f1prev_d   = f1_sat;
                f2_d       = f2_sat;
                overflow_d = overflow_q | f1_clamp | f2_clamp;
                state_d    = S_WRF2;
            end
            S_WRF2: begin
                scratch_mem_write_en   = 1'b1;
                scratch_mem_write_addr = {LSP_F, 1'b1, idx_next};
                scratch_mem_out        = {{16{f2_q[15]}}, f2_q};
                f2prev_d = f2_q;
                if (i_q == 3'd4) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 3'd1;
                    state_d = S_RDA;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The RAM registers the address, so the read address is driven
    // combinationally in RDA/RDB and held from its register otherwise.
    assign scratch_mem_read_addr = read_addr_d;
    assign busy     = (state_q != S_IDLE);
    assign overflow = overflow_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            i_q         <= 3'd0;
            a_lo_q      <= 16'd0;
            f1prev_q    <= 16'd0;
            f2prev_q    <= 16'd0;
            f2_q        <= 16'd0;
            overflow_q  <= 1'b0;
            read_addr_q <= 7'd0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            a_lo_q      <= a_lo_d;
            f1prev_q    <= f1prev_d;
            f2prev_q    <= f2prev_d;
            f2_q        <= f2_d;
            overflow_q  <= overflow_d;
            read_addr_q <= read_addr_d;
        end
    end

endmodule

// File: tb/tb_az_to_lsp_f_poly.sv
// Bench for az_to_lsp_f_poly: scratch RAM model, directed and random a[] sets,
// results compared against a plain-arithmetic polynomial model.
module tb_az_to_lsp_f_poly;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        done, busy, overflow;
    logic [6:0]  raddr, waddr;
    logic [31:0] rdata, wout;
    logic        we;

    logic [31:0] mem [128];
    logic        tb_we;
    logic [6:0]  tb_addr;
    logic [31:0] tb_data;
    int          wr_cnt, bad_wr, done_cnt;

    int n_chk, n_fail;
    int a_v [1:10];
    int exp_f1 [0:5];
    int exp_f2 [0:5];
    bit exp_ov;

    az_to_lsp_f_poly dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .done                   (done),
        .busy                   (busy),
        .overflow               (overflow),
        .scratch_mem_read_addr  (raddr),
        .scratch_mem_in         (rdata),
        .scratch_mem_write_addr (waddr),
        .scratch_mem_out        (wout),
        .scratch_mem_write_en   (we)
    );

    always #5 clock = ~clock;

    initial begin
        wr_cnt = 0; bad_wr = 0; done_cnt = 0;
    end

    always @(posedge clock) begin
        rdata <= mem[raddr];
        if (tb_we) mem[tb_addr] = tb_data;
        if (we) begin
            mem[waddr] = wout;
            wr_cnt++;
            if (waddr[6:5] != 2'b01 || wout[31:16] != {16{wout[15]}} || raddr == waddr) bad_wr++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int sat(input int v, inout bit ov);
        if (v > 32767) begin ov = 1; return 32767; end
        if (v < -32768) begin ov = 1; return -32768; end
        return v;
    endfunction

    task automatic model();
        int lo, hi;
        exp_ov = 0;
        exp_f1[0] = 2048;
        exp_f2[0] = 2048;
        for (int k = 1; k <= 5; k++) begin
            lo = a_v[k];
            hi = a_v[11-k];
            exp_f1[k] = sat(((lo + hi) >>> 1) - exp_f1[k-1], exp_ov);
            exp_f2[k] = sat(((lo - hi) >>> 1) + exp_f2[k-1], exp_ov);
        end
    endtask

    task automatic poke(input logic [6:0] ad, input logic [31:0] dat);
        @(negedge clock);
        tb_we = 1'b1; tb_addr = ad; tb_data = dat;
    endtask

    task automatic load();
        logic [15:0] lo16;
        for (int k = 1; k <= 10; k++) begin
            lo16 = 16'(a_v[k]);
            poke(7'(64 + k), {16'($urandom), lo16});
        end
        for (int k = 0; k <= 5; k++) begin
            poke(7'(32 + k), 32'hdeadbeef);
            poke(7'(48 + k), 32'hdeadbeef);
        end
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    task automatic run_check(input string name, input bit glitch);
        int cyc, w0, b0, d0, busy_bad;
        logic [31:0] ev;
        load();
        model();
        w0 = wr_cnt; b0 = bad_wr; d0 = done_cnt;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        cyc = 1;
        chk({name, " ovf_clear"}, 32'(overflow), 32'd0);
        busy_bad = 0;
        while (!done && cyc < 60) begin
            if (busy !== 1'b1 || (cyc < 23 && done)) busy_bad++;
            @(negedge clock);
            cyc++;
            start = glitch && (cyc == 5 || cyc == 12);
        end
        start = 1'b0;
        chk({name, " latency"}, 32'(cyc), 32'd23);
        chk({name, " busy_run"}, 32'(busy_bad), 32'd0);
        chk({name, " busy_done"}, 32'(busy), 32'd1);
        @(negedge clock);
        chk({name, " done_pulse"}, 32'(done), 32'd0);
        chk({name, " busy_idle"}, 32'(busy), 32'd0);
        repeat (20) @(negedge clock);
        chk({name, " writes"}, 32'(wr_cnt - w0), 32'd12);
        chk({name, " done_cnt"}, 32'(done_cnt - d0), 32'd1);
        chk({name, " bad_writes"}, 32'(bad_wr - b0), 32'd0);
        chk({name, " overflow"}, 32'(overflow), 32'(exp_ov));
        for (int k = 0; k <= 5; k++) begin
            ev = 32'(exp_f1[k]);
            chk($sformatf("%s f1[%0d]", name, k), mem[7'(32 + k)], ev);
            ev = 32'(exp_f2[k]);
            chk($sformatf("%s f2[%0d]", name, k), mem[7'(48 + k)], ev);
        end
        for (int k = 1; k <= 10; k++) begin
            ev = 32'(a_v[k]);
            chk($sformatf("%s a[%0d]", name, k), 32'(mem[7'(64 + k)][15:0]), 32'(ev[15:0]));
        end
    endtask

    task automatic set_a(input int a1, input int a10);
        for (int k = 1; k <= 10; k++) a_v[k] = 0;
        a_v[1]  = a1;
        a_v[10] = a10;
    endtask

    initial begin
        int cyc;
        n_chk = 0; n_fail = 0;
        start = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        for (int k = 0; k < 128; k++) mem[k] = 32'h0;
        reset = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst we", 32'(we), 32'd0);
        chk("rst ovf", 32'(overflow), 32'd0);
        chk("rst raddr", 32'(raddr), 32'd0);
        chk("rst wout", wout, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        set_a(0, 0);          run_check("zero", 1'b0);
        set_a(100, 50);       run_check("a1_100", 1'b0);
        set_a(3, 0);          run_check("floor_pos", 1'b0);
        set_a(-3, 0);         run_check("floor_neg", 1'b0);
        set_a(32767, -32768); run_check("sat", 1'b0);
        set_a(0, 0);          run_check("glitch", 1'b1);

        // abort mid-run with an asynchronous reset
        load();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        for (cyc = 1; cyc < 10; cyc++) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort we", 32'(we), 32'd0);
        chk("abort waddr", 32'(waddr), 32'd0);
        chk("abort raddr", 32'(raddr), 32'd0);
        chk("abort wout", wout, 32'd0);
        @(negedge clock) reset = 1'b1;

        for (int r = 0; r < 8; r++) begin
            for (int k = 1; k <= 10; k++) begin
                if (r < 4) a_v[k] = int'($urandom_range(0, 8191)) - 4096;
                else       a_v[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            run_check($sformatf("rand%0d", r), r[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/az_to_lsp_f_poly.md
Name: az_to_lsp_f_poly

Overview:
Front end of the Az-to-LSP conversion. It is the inverse direction of the LSP-to-Az stage.
- Reads the LPC coefficients a[1..10] (Q12) from scratch memory.
- Forms the symmetric/antisymmetric sum polynomials f1[0..5] and f2[0..5].
- Writes them back to the LSP_F region, where the Chebyshev root search will consume them.
- Uses the same scratch-memory map as the LSP-to-Az stage.

Parameters:
- LSP_A, 3'd4: scratch region holding a[]; address = {LSP_A, i[3:0]}.
- LSP_F, 2'd1: scratch region for f polys; f1[i] at {LSP_F, 1'b0, i[3:0]}, f2[i] at {LSP_F, 1'b1, i[3:0]}.
- F_INIT, 16'd2048: value written to f1[0] and f2[0].

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle request; sampled only in IDLE.
- done, output, 1: one-cycle pulse when all 12 f values are written.
- busy, output, 1: high from the cycle after start is accepted until done.
- overflow, output, 1: sticky saturation flag; cleared when start is accepted.
- scratch_mem_read_addr, output, 7: read address.
- scratch_mem_in, input, 32: read data; registered RAM, valid the cycle after the address; [15:0] used as signed.
- scratch_mem_write_addr, output, 7: write address.
- scratch_mem_out, output, 32: write data, sign-extended from 16 bits.
- scratch_mem_write_en, output, 1: write strobe, single cycle per word.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - done=0, busy=0, overflow=0, write_en=0.
  - All addresses = 0, scratch_mem_out = 0.
  - Internal a_lo, f1prev, f2prev and loop index i are cleared.
  - Asserting reset mid-operation aborts the operation; no further writes occur; the memory contents are left partially written.
- States:
  - IDLE -> INIT0 on start=1. start is ignored in every other state; there is no queuing.
  - INIT0: write F_INIT to f1[0]; f1prev=2048; i=0.
  - INIT1: write F_INIT to f2[0]; f2prev=2048.
  - RDA: read_addr = {LSP_A, i+1}.
  - RDB: read_addr = {LSP_A, 10-i}; latch a_lo = scratch_mem_in[15:0].
  - CALC: a_hi = scratch_mem_in[15:0].
    - s = a_lo + a_hi (17 bit); x = s >>> 1 (arithmetic, floor).
    - f1 = sat16(x - f1prev) (18-bit intermediate).
    - Write f1 to {LSP_F, 0, i+1}; f1prev = f1.
    - Also compute d = a_lo - a_hi (17 bit); y = d >>> 1; f2 = sat16(y + f2prev); hold f2 in a register.
  - WRF2: write f2 to {LSP_F, 1, i+1}; f2prev = f2.
    - If i == 4: go to DONE.
    - Otherwise: i = i+1, go to RDA.
  - DONE: done=1 for one cycle -> IDLE.
- Saturation: sat16 clamps to [-32768, 32767]. Any clamp sets overflow, which stays set until the next accepted start.
- Latency: start sampled high in cycle 0 -> done high in cycle 23 (2 + 5×4 + 1). busy is high in cycles 1..23.
- Writes:
  - Exactly 12 writes per run.
  - write_en is never high in IDLE, RDA, RDB or DONE.
  - No read and write to the same address in the same cycle.
- Memory: a[] is never written by this block.
- Addresses:
  - read_addr holds its last value outside RDA/RDB.
  - write_addr and scratch_mem_out are 0 when write_en=0.
- Back-to-back: start in the cycle after done (IDLE) is accepted normally.

Test Plan:
- All a[1..10]=0; pulse start.
  - f1[0..5] = 2048, -2048, 2048, -2048, 2048, -2048.
  - f2[0..5] all 2048.
  - done in cycle 23; overflow=0; exactly 12 write strobes.
- a[1]=100, a[10]=50, others 0 -> f1[1] = -1973, f2[1] = 2073, f1[2] = 1973, f2[2] = 2073.
- Floor rounding:
  - a[1]=3, a[10]=0 -> f1[1] = 1-2048 = -2047.
  - a[1]=-3, a[10]=0 -> f1[1] = -2-2048 = -2050; f2[1] = -2+2048 = 2046.
- Saturation: a[1]=32767, a[10]=-32768 -> f2[1] = 32767 (clamped), overflow=1. The next start clears overflow.
- start pulsed again at cycles 5 and 12 of a run -> ignored; single done at cycle 23; no extra writes.
- reset driven low asynchronously in cycle 10 -> outputs immediately 0, FSM in IDLE; a fresh start completes a full correct run of 23 cycles.
